// File: rtl/icache_dm_pkg.sv
// cache_types: shared types and geometry for the direct-mapped instruction cache.
//   S_OFFSET / S_INDEX : log2 line bytes / log2 set count
//   S_TAG              : derived tag width (not overridable)
//   icache_state_t     : controller state encoding
//   cacheline_t        : one 256-bit cache line
package cache_types;

  localparam int S_OFFSET = 5;
  localparam int S_INDEX  = 3;
  localparam int S_TAG    = 32 - S_OFFSET - S_INDEX;
  localparam int NUM_SETS = 1 << S_INDEX;
  localparam int S_WORD   = S_OFFSET - 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FILL  = 2'd2
  } icache_state_t;

  typedef logic [255:0] cacheline_t;

  // Line-aligned byte address for a given fetch address.
  function automatic logic [31:0] line_base(input logic [31:0] addr);
    return {addr[31:S_OFFSET], {S_OFFSET{1'b0}}};
  endfunction

endpackage

// File: rtl/icache_dm_if.sv
// Bus interfaces of the instruction cache.
//   icache_cpu_if  : IF-stage fetch port (master = CPU, slave = cache)
//     icache_read, icache_address -> cache ; icache_rdata, icache_resp -> CPU
//   icache_pmem_if : line-fill port (master = cache, slave = memory/adaptor)
//     pmem_read, pmem_address -> memory ; pmem_rdata, pmem_resp -> cache
interface icache_cpu_if;
  logic        icache_read;
  logic [31:0] icache_address;
  logic [31:0] icache_rdata;
  logic        icache_resp;

  modport master (output icache_read, icache_address, input  icache_rdata, icache_resp);
  modport slave  (input  icache_read, icache_address, output icache_rdata, icache_resp);
endinterface

interface icache_pmem_if;
  import cache_types::*;
  logic        pmem_read;
  logic [31:0] pmem_address;
  cacheline_t  pmem_rdata;
  logic        pmem_resp;

  modport master (output pmem_read, pmem_address, input  pmem_rdata, pmem_resp);
  modport slave  (input  pmem_read, pmem_address, output pmem_rdata, pmem_resp);
endinterface

// File: rtl/icache_dm_array.sv
// icache_array: valid/tag/data storage for the direct-mapped cache, all in flops.
//   clk, rst        : clock, async active-low reset (clears valid bits only)
//   we/widx/wtag/wdata : single write port, installs a whole line
//   ridx            : combinational read index
//   rvalid/rtag/rdata  : combinational read data for ridx
module icache_array
  import cache_types::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [S_INDEX-1:0] widx,
  input  logic [S_TAG-1:0]   wtag,
  input  cacheline_t         wdata,
  input  logic [S_INDEX-1:0] ridx,
  output logic               rvalid,
  output logic [S_TAG-1:0]   rtag,
  output cacheline_t         rdata
);

  logic [NUM_SETS-1:0] valid_q;
  logic [S_TAG-1:0]    tag_q  [NUM_SETS];
  cacheline_t          data_q [NUM_SETS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q[widx] <= 1'b1;
    end
  end

  // Tag and data need no reset: they are never observed while valid is clear.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_q[widx]  <= wtag;
      data_q[widx] <= wdata;
    end
  end

  assign rvalid = valid_q[ridx];
  assign rtag   = tag_q[ridx];
  assign rdata  = data_q[ridx];

endmodule

// File: rtl/icache_dm.sv
// icache_dm: direct-mapped read-only L1 instruction cache.
//   clk  : clock, rising edge
//   rst  : async active-low reset
//   cpu  : fetch port (slave); hits answer combinationally in the request cycle
//   pmem : line-fill port (master); one 256-bit line per miss
//
// state | meaning
// IDLE  | lookup; hit answers same cycle, miss captures line address
// FETCH | fill request outstanding on pmem, waiting for pmem_resp
// FILL  | fill buffer written into the array; lookup resumes next cycle
module icache_dm
  import cache_types::*;
(
  input  logic           clk,
  input  logic           rst,
  icache_cpu_if.slave    cpu,
  icache_pmem_if.master  pmem
);

  icache_state_t          state;
  logic [31:S_OFFSET]     miss_addr;
  cacheline_t             fill_buf;
  logic                   pmem_read_q;
  logic [31:0]            pmem_addr_q;

  logic [S_TAG-1:0]       req_tag;
  logic [S_INDEX-1:0]     req_idx;
  logic [S_WORD-1:0]      req_word;
  logic                   arr_valid;
  logic [S_TAG-1:0]       arr_tag;
  cacheline_t             arr_line;
  logic                   hit;
  logic                   unused_addr_bits;

  assign req_tag  = cpu.icache_address[31 -: S_TAG];
  assign req_idx  = cpu.icache_address[S_OFFSET +: S_INDEX];
  assign req_word = cpu.icache_address[S_OFFSET-1:2];
  assign unused_addr_bits = ^cpu.icache_address[1:0];

  icache_array u_array (
    .clk    (clk),
    .rst    (rst),
    .we     (state == FILL),
    .widx   (miss_addr[S_OFFSET +: S_INDEX]),
    .wtag   (miss_addr[31 -: S_TAG]),
    .wdata  (fill_buf),
    .ridx   (req_idx),
    .rvalid (arr_valid),
    .rtag   (arr_tag),
    .rdata  (arr_line)
  );

  // Only IDLE performs lookups, so the cycle in FILL never answers early.
  assign hit = (state == IDLE) && cpu.icache_read && arr_valid && (arr_tag == req_tag);

  assign cpu.icache_resp  = hit;
  assign cpu.icache_rdata = hit ? arr_line[{req_word, 5'b0} +: 32] : 32'h0;

  assign pmem.pmem_read    = pmem_read_q;
  assign pmem.pmem_address = pmem_addr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      miss_addr   <= '0;
      fill_buf    <= '0;
      pmem_read_q <= 1'b0;
      pmem_addr_q <= 32'h0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cpu.icache_read && !hit) begin
            miss_addr   <= cpu.icache_address[31:S_OFFSET];
            pmem_addr_q <= line_base(cpu.icache_address);
            pmem_read_q <= 1'b1;
            state       <= FETCH;
          end
        end
        FETCH: begin
          // The fill completes even if the CPU drops or changes its request.
          if (pmem.pmem_resp) begin
            fill_buf    <= pmem.pmem_rdata;
            pmem_read_q <= 1'b0;
            state       <= FILL;
          end
        end
        FILL: begin
          state <= IDLE;
        end
        default: begin
          pmem_read_q <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_dm.sv
module tb_icache_dm;
  import cache_types::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  icache_cpu_if  cpu ();
  icache_pmem_if pmem ();

  icache_dm dut (
    .clk  (clk),
    .rst  (rst),
    .cpu  (cpu),
    .pmem (pmem)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          lat;
  } exp_t;

  exp_t        sbq[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          req_cycle = 0;
  int          mem_lat = 1;
  logic [31:0] exp_line = 32'h0;
  int          stray_req = 0;

  // Reference model: which line each set currently holds.
  bit          ref_valid [8];
  logic [23:0] ref_tag   [8];

  always @(posedge clk) cyc <= cyc + 1;

  // Backing memory contents: a fixed function of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    return (wa * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic cacheline_t mem_line(input logic [31:0] la);
    cacheline_t l;
    logic [2:0] w;
    for (int i = 0; i < 8; i++) begin
      w = 3'(i);
      l[i*32 +: 32] = mem_word({la[31:5], w, 2'b00});
    end
    return l;
  endfunction

  function automatic bit ref_hit(input logic [31:0] a);
    return ref_valid[a[7:5]] && (ref_tag[a[7:5]] == a[31:8]);
  endfunction

  task automatic ref_install(input logic [31:0] a);
    ref_valid[a[7:5]] = 1'b1;
    ref_tag[a[7:5]]   = a[31:8];
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the cache answers.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (cpu.icache_resp) begin
          check("resp_needs_read", {31'b0, cpu.icache_read}, 32'h1);
          check("pmem_read_on_hit", {31'b0, pmem.pmem_read}, 32'h0);
          if (sbq.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_resp: got resp=1 addr %h expected resp=0", cpu.icache_address);
          end else begin
            e = sbq.pop_front();
            check("rdata", cpu.icache_rdata, e.data);
            check("latency", 32'(cyc - req_cycle), 32'(e.lat));
          end
        end else begin
          check("rdata_zero_no_resp", cpu.icache_rdata, 32'h0);
        end
      end
    end
  end

  // Memory slave: answers a fill after mem_lat cycles, or emits stray pulses on request.
  initial begin
    logic [31:0] la;
    int stray_done;
    stray_done = 0;
    pmem.pmem_resp  = 1'b0;
    pmem.pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (stray_done < stray_req) begin
        stray_done++;
        pmem.pmem_rdata = ~mem_line(32'h60);
        pmem.pmem_resp  = 1'b1;
        @(negedge clk);
        pmem.pmem_resp  = 1'b0;
      end else if (pmem.pmem_read) begin
        la = pmem.pmem_address;
        check("pmem_address", la, exp_line);
        for (int k = 1; k < mem_lat; k++) @(negedge clk);
        pmem.pmem_rdata = mem_line(la);
        pmem.pmem_resp  = 1'b1;
        @(negedge clk);
        pmem.pmem_resp  = 1'b0;
        pmem.pmem_rdata = '0;
      end
    end
  end

  task automatic issue(input logic [31:0] a, input int lat);
    bit h;
    @(posedge clk); #1;
    cpu.icache_read    = 1'b1;
    cpu.icache_address = a;
    mem_lat   = lat;
    req_cycle = cyc;
    exp_line  = {a[31:5], 5'b0};
    h = ref_hit(a);
    sbq.push_back('{a, mem_word(a), h ? 0 : lat + 2});
    if (!h) ref_install(a);
  endtask

  task automatic do_read(input logic [31:0] a, input int lat);
    int n;
    issue(a, lat);
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (cpu.icache_resp) break;
      n++;
    end
    if (n == 40) begin
      vectors++;
      miscompares++;
      $display("FAIL resp_timeout: got no resp for %h expected resp within 40 cycles", a);
      if (sbq.size() > 0) void'(sbq.pop_front());
    end
    @(posedge clk); #1;
    cpu.icache_read = 1'b0;
  endtask

  // Miss whose request is withdrawn while the fill is outstanding.
  task automatic do_drop(input logic [31:0] a, input int lat);
    @(posedge clk); #1;
    cpu.icache_read    = 1'b1;
    cpu.icache_address = a;
    mem_lat  = lat;
    exp_line = {a[31:5], 5'b0};
    @(posedge clk); #1;
    cpu.icache_read = 1'b0;
    repeat (lat + 4) @(posedge clk);
    ref_install(a);
  endtask

  initial begin
    logic [31:0] a;
    int lat;
    for (int i = 0; i < 8; i++) begin
      ref_valid[i] = 1'b0;
      ref_tag[i]   = '0;
    end
    rst = 1'b0;
    cpu.icache_read    = 1'b0;
    cpu.icache_address = 32'h0;
    #2;
    check("reset_resp", {31'b0, cpu.icache_resp}, 32'h0);
    check("reset_pmem_read", {31'b0, pmem.pmem_read}, 32'h0);
    check("reset_pmem_address", pmem.pmem_address, 32'h0);
    check("reset_rdata", cpu.icache_rdata, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Cold miss, hit in same line, conflict in set 3, re-miss.
    do_read(32'h0000_0060, 5);
    do_read(32'h0000_0064, 1);
    do_read(32'h0000_0160, 3);
    do_read(32'h0000_0060, 2);
    do_read(32'h0000_007C, 1);

    // Request dropped during FETCH still installs the line.
    do_drop(32'h0000_0080, 4);
    do_read(32'h0000_0084, 1);

    // A pmem_resp pulse in IDLE must not corrupt the resident line.
    stray_req++;
    repeat (4) @(posedge clk);
    do_read(32'h0000_0068, 1);

    // Async reset while a fill is outstanding.
    do_read(32'h0000_0060, 1);
    @(posedge clk); #1;
    cpu.icache_read    = 1'b1;
    cpu.icache_address = 32'h0000_02A0;
    mem_lat  = 6;
    exp_line = 32'h0000_02A0;
    @(posedge clk); #3;
    check("fetch_pmem_read", {31'b0, pmem.pmem_read}, 32'h1);
    rst = 1'b0;
    cpu.icache_read = 1'b0;
    #1;
    check("rst_pmem_read_drop", {31'b0, pmem.pmem_read}, 32'h0);
    check("rst_pmem_address", pmem.pmem_address, 32'h0);
    for (int i = 0; i < 8; i++) ref_valid[i] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (8) @(posedge clk);
    do_read(32'h0000_0060, 3);

    // No requests: random addresses, nothing may happen.
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      cpu.icache_read    = 1'b0;
      cpu.icache_address = $urandom;
      @(negedge clk);
      check("idle_pmem_read", {31'b0, pmem.pmem_read}, 32'h0);
    end
    do_read(32'h0000_0070, 1);

    // Random traffic over a few tags so hits and conflicts both occur.
    for (int i = 0; i < 60; i++) begin
      a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 5) | ($urandom_range(0, 7) << 2);
      if ($urandom_range(0, 7) == 0) a = a | 32'hA500_0000;
      lat = $urandom_range(1, 5);
      if (!ref_hit(a) && $urandom_range(0, 5) == 0) do_drop(a, lat);
      else do_read(a, lat);
    end

    repeat (3) @(posedge clk);
    if (sbq.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500us");
    $fatal(1);
  end

endmodule
